// File: rtl/bsg_piso_reset_en.sv
// rtl/bsg_piso_reset_en.sv - parallel-in serial-out transmitter, optional macro BSG_PISO_MSB_FIRST_EN
module bsg_piso_reset_en #(
    parameter int width_p = 4,
    parameter int els_p   = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       valid_i,
    input  logic [els_p*width_p-1:0]   data_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output logic [width_p-1:0]         data_o,
    input  logic                       yumi_i,
    output logic                       last_o
);

    localparam int cnt_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam logic [cnt_w-1:0] last_cnt = cnt_w'(els_p - 1);

    localparam logic [0:0] st_idle = 1'b0;
    localparam logic [0:0] st_send = 1'b1;

    logic [0:0]               state_r;
    logic [cnt_w-1:0]         cnt_r;
    logic [els_p*width_p-1:0] data_r;
    logic [width_p-1:0]       chunk [els_p];
    logic [cnt_w-1:0]         sel;

    // Split the stored word into its chunks so the output mux is a plain array index
    always_comb begin
        for (int k = 0; k < els_p; k++) begin
            chunk[k] = data_r[k*width_p +: width_p];
        end
    end

    // Pick which chunk the counter refers to; the counter itself always counts up
    always_comb begin
`ifdef BSG_PISO_MSB_FIRST_EN
        sel = last_cnt - cnt_r;
`else
        sel = cnt_r;
`endif
    end

    // All outputs come from registered state only, never from valid_i or yumi_i
    always_comb begin
        ready_o = (state_r == st_idle);
        valid_o = (state_r == st_send);
        data_o  = chunk[sel];
        last_o  = valid_o && (cnt_r == last_cnt);
    end

    // Load on the input handshake, advance on each consumed chunk, drop back to idle after the last
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= st_idle;
            cnt_r   <= '0;
            data_r  <= '0;
        end else begin
            case (state_r)
                st_idle: begin
                    if (valid_i) begin
                        data_r  <= data_i;
                        cnt_r   <= '0;
                        state_r <= st_send;
                    end
                end
                default: begin
                    if (yumi_i) begin
                        if (cnt_r == last_cnt) begin
                            cnt_r   <= '0;
                            state_r <= st_idle;
                        end else begin
                            cnt_r <= cnt_r + cnt_w'(1);
                        end
                    end
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // The consumer may only take a chunk that is actually being offered
    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !valid_o));
`endif

endmodule

// File: tb/tb_bsg_piso_reset_en.sv
// tb/tb_bsg_piso_reset_en.sv - directed self-checking bench for bsg_piso_reset_en
module tb_bsg_piso_reset_en;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        valid_i;
    logic [15:0] data_i;
    logic        ready_o;
    logic        valid_o;
    logic [3:0]  data_o;
    logic        yumi_i;
    logic        last_o;

    int total = 0;
    int bad   = 0;

    bsg_piso_reset_en #(.width_p(4), .els_p(4)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .yumi_i  (yumi_i),
        .last_o  (last_o)
    );

    always #5 clk_i = ~clk_i;

    // Emission order: beat i carries chunk i, or chunk 3-i when MSB-first
    function automatic logic [3:0] exp_chunk(input logic [15:0] w, input int i);
        logic [15:0] t;
        int idx;
`ifdef BSG_PISO_MSB_FIRST_EN
        idx = 3 - i;
`else
        idx = i;
`endif
        t = w >> (idx * 4);
        return t[3:0];
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load(input logic [15:0] w);
        check("load_ready", {15'd0, ready_o}, 16'd1);
        valid_i = 1'b1;
        data_i  = w;
        tick();
        valid_i = 1'b0;
        data_i  = 16'h0000;
    endtask

    // Consume beats first..3 at full rate, checking each offered chunk
    task automatic drain(input string tag, input logic [15:0] w, input int first);
        for (int i = first; i < 4; i++) begin
            check({tag, "_valid"}, {15'd0, valid_o}, 16'd1);
            check({tag, "_ready"}, {15'd0, ready_o}, 16'd0);
            check({tag, "_data"},  {12'd0, data_o}, {12'd0, exp_chunk(w, i)});
            check({tag, "_last"},  {15'd0, last_o}, (i == 3) ? 16'd1 : 16'd0);
            yumi_i = 1'b1;
            tick();
            yumi_i = 1'b0;
        end
        check({tag, "_end_ready"}, {15'd0, ready_o}, 16'd1);
        check({tag, "_end_valid"}, {15'd0, valid_o}, 16'd0);
    endtask

    initial begin
        reset_i = 1'b0;
        valid_i = 1'b0;
        yumi_i  = 1'b0;
        data_i  = 16'h0000;

        // Asynchronous reset asserted between clock edges
        #2;
        reset_i = 1'b1;
        #1;
        check("rst_ready", {15'd0, ready_o}, 16'd1);
        check("rst_valid", {15'd0, valid_o}, 16'd0);
        check("rst_last",  {15'd0, last_o}, 16'd0);
        check("rst_data",  {12'd0, data_o}, 16'd0);
        tick();
        tick();
        reset_i = 1'b0;

        // Idle with no input
        for (int c = 0; c < 5; c++) begin
            tick();
            check("idle_ready", {15'd0, ready_o}, 16'd1);
            check("idle_valid", {15'd0, valid_o}, 16'd0);
            check("idle_last",  {15'd0, last_o}, 16'd0);
        end

        // Basic serialisation at full yumi rate
        load(16'hA5C3);
        drain("basic", 16'hA5C3, 0);

        // Backpressure on beat 1
        load(16'h1234);
        check("bp_c0", {12'd0, data_o}, {12'd0, exp_chunk(16'h1234, 0)});
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("bp_hold_data",  {12'd0, data_o}, {12'd0, exp_chunk(16'h1234, 1)});
            check("bp_hold_valid", {15'd0, valid_o}, 16'd1);
            tick();
        end
        drain("bp", 16'h1234, 1);

        // New word offered while sending is ignored until ready_o returns
        load(16'h0F0F);
        valid_i = 1'b1;
        data_i  = 16'hFFFF;
        drain("ign", 16'h0F0F, 0);
        tick();
        valid_i = 1'b0;
        data_i  = 16'h0000;
        drain("ign2", 16'hFFFF, 0);

        // Reset after two beats consumed
        load(16'h5678);
        yumi_i = 1'b1;
        tick();
        tick();
        yumi_i = 1'b0;
        check("mid_pre_valid", {15'd0, valid_o}, 16'd1);
        #2;
        reset_i = 1'b1;
        #1;
        check("mid_rst_valid", {15'd0, valid_o}, 16'd0);
        check("mid_rst_ready", {15'd0, ready_o}, 16'd1);
        check("mid_rst_data",  {12'd0, data_o}, 16'd0);
        tick();
        reset_i = 1'b0;
        tick();
        check("mid_idle_valid", {15'd0, valid_o}, 16'd0);
        load(16'h00AB);
        drain("post", 16'h00AB, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
